alu_share_arbiter: RTL

- Multi-cycle controller that shares one combinational 32-bit ALU (add/sub/slt/and/or/xor, 4-bit alucontrol, aluout and zero outputs) among NREQ requesters.
- Each requester uses a valid/ready command channel. All requesters share one response channel, tagged with the requester ID.
- The block arbitrates, registers the operands, drives the external ALU, captures the result and holds it until it is consumed.
- Sits between the core datapath / calculator front-end and the shared ALU instance.

---
 rtl/alu_share_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// ============================================================================
// alu_share_arbiter : shares one 32-bit ALU among NREQ valid/ready requesters
// Option macro: ALU_SHARE_FIXED_PRIO_EN (fixed priority instead of round-robin)
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_share_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*32-1:0]  req_srca,
  input  logic [NREQ*32-1:0]  req_srcb,
  input  logic [NREQ*4-1:0]   req_ctrl,
  output logic [31:0]         alu_srca,
  output logic [31:0]         alu_srcb,
  output logic [3:0]          alu_ctrl,
  input  logic [31:0]         alu_result,
  input  logic                alu_zero,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_data,
  output logic                rsp_zero,
  output logic                rsp_err,
  output logic [IDW-1:0]      rsp_id
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]     state;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] id_q;
  logic           err_q;

  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [31:0]    sel_srca;
  logic [31:0]    sel_srcb;
  logic [3:0]     sel_ctrl;
  logic           ctrl_ok;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
`ifdef ALU_SHARE_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_found && req_valid[i]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(i);
      end
    end
`else
    // Search above last_grant first, then wrap around to the low indices.
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_found && req_valid[i] && (i > int'(last_grant))) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_found && req_valid[i] && (i <= int'(last_grant))) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(i);
      end
    end
`endif
  end

  always_comb begin
    sel_srca = '0;
    sel_srcb = '0;
    sel_ctrl = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_srca = req_srca[32*i +: 32];
        sel_srcb = req_srcb[32*i +: 32];
        sel_ctrl = req_ctrl[4*i +: 4];
      end
    end
  end

  always_comb begin
    ctrl_ok = 1'b0;
    case (sel_ctrl)
      4'b0000, 4'b1000, 4'b0010,
      4'b0110, 4'b0111, 4'b0100: ctrl_ok = 1'b1;
      default:                   ctrl_ok = 1'b0;
    endcase
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = (state == ST_IDLE) && grant_found && (grant_idx == IDW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= IDW'(NREQ - 1);
      id_q       <= '0;
      err_q      <= 1'b0;
      alu_srca   <= '0;
      alu_srcb   <= '0;
      alu_ctrl   <= 4'b0000;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_id     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_found) begin
            alu_srca   <= sel_srca;
            alu_srcb   <= sel_srcb;
            alu_ctrl   <= ctrl_ok ? sel_ctrl : 4'b0000;
            err_q      <= !ctrl_ok;
            id_q       <= grant_idx;
            last_grant <= grant_idx;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // Response fields are updated together so rsp_id never leads the data.
          rsp_data  <= err_q ? 32'd0 : alu_result;
          rsp_zero  <= err_q ? 1'b0 : alu_zero;
          rsp_err   <= err_q;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
